// File: rtl/fpr_bank_swap_seq_pkg.sv
// Core definitions shared by the FR/XF bank-swap sequencer: register ids, states, widths.
// FPR_SWAP_64_EN selects pair (64-bit) transfers instead of single (32-bit) transfers.
package fpr_bank_swap_seq_pkg;

  localparam int unsigned RegIdW = 7;

  localparam logic [RegIdW-1:0] UREG_ZZR  = 7'h00;
  localparam logic [RegIdW-1:0] UREG_FR0  = 7'h20;
  localparam logic [RegIdW-1:0] UREG_XF0  = 7'h30;
  localparam logic [RegIdW-1:0] UREG_FPUL = 7'h41;

  localparam logic [1:0] ModeSingle = 2'd0;
  localparam logic [1:0] ModePair   = 2'd1;

`ifdef FPR_SWAP_64_EN
  localparam int unsigned HoldW   = 64;
  localparam logic [3:0]  IdxLast = 4'd7;
`else
  localparam int unsigned HoldW   = 32;
  localparam logic [3:0]  IdxLast = 4'd15;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StWrbk
  } swap_state_e;

  function automatic logic [RegIdW-1:0] ureg_fr(input logic [3:0] idx);
    return UREG_FR0 | {3'b000, idx};
  endfunction

  function automatic logic [RegIdW-1:0] ureg_xf(input logic [3:0] idx);
    return UREG_XF0 | {3'b000, idx};
  endfunction

endpackage

// File: rtl/fpr_bank_swap_seq_if.sv
// Pipeline-side and register-file-side signals of the bank-swap sequencer.
interface fpr_bank_swap_seq_if;
  import fpr_bank_swap_seq_pkg::*;

  logic              swap_req;
  logic              swap_busy;
  logic              swap_done;
  logic              pipe_stall;

  logic [RegIdW-1:0] pipe_id_rs;
  logic [RegIdW-1:0] pipe_id_rt;
  logic [1:0]        pipe_mode;
  logic [RegIdW-1:0] pipe_id_ro;
  logic [63:0]       pipe_val_ro;
  logic [1:0]        pipe_st_mode;

  logic [RegIdW-1:0] reg_id_rs;
  logic [RegIdW-1:0] reg_id_rt;
  logic [1:0]        reg_mode;
  logic [RegIdW-1:0] reg_id_ro;
  logic [63:0]       reg_val_ro;
  logic [1:0]        reg_st_mode;

  logic [63:0]       reg_val_rs;
  logic [63:0]       reg_val_rt;

  // Pipeline and register file side.
  modport master (
    output swap_req, pipe_id_rs, pipe_id_rt, pipe_mode, pipe_id_ro, pipe_val_ro, pipe_st_mode,
    output reg_val_rs, reg_val_rt,
    input  swap_busy, swap_done, pipe_stall,
    input  reg_id_rs, reg_id_rt, reg_mode, reg_id_ro, reg_val_ro, reg_st_mode
  );

  // Sequencer side.
  modport slave (
    input  swap_req, pipe_id_rs, pipe_id_rt, pipe_mode, pipe_id_ro, pipe_val_ro, pipe_st_mode,
    input  reg_val_rs, reg_val_rt,
    output swap_busy, swap_done, pipe_stall,
    output reg_id_rs, reg_id_rt, reg_mode, reg_id_ro, reg_val_ro, reg_st_mode
  );

endinterface

// File: rtl/fpr_bank_swap_seq.sv
// FR<->XF bank exchange sequencer: borrows the register-file ports for a read/write sweep.
// FPR_SWAP_64_EN: eight pair transfers instead of sixteen single transfers.
module fpr_bank_swap_seq
  import fpr_bank_swap_seq_pkg::*;
(
  input logic                 clk_i,
  input logic                 rst_ni,
  fpr_bank_swap_seq_if.slave  bus_io
);

  swap_state_e      state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             idx_last;

  assign idx_last = (idx_q == IdxLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Control and id muxing; read data is handled separately so that the
  // id -> register file -> read data path never closes a loop through one process.
  always_comb begin
    state_d              = state_q;
    idx_d                = idx_q;
    bus_io.swap_busy     = 1'b0;
    bus_io.swap_done     = 1'b0;
    bus_io.pipe_stall    = 1'b0;
    bus_io.reg_id_rs     = bus_io.pipe_id_rs;
    bus_io.reg_id_rt     = bus_io.pipe_id_rt;
    bus_io.reg_mode      = bus_io.pipe_mode;
    bus_io.reg_id_ro     = bus_io.pipe_id_ro;
    bus_io.reg_st_mode   = bus_io.pipe_st_mode;

    unique case (state_q)
      StIdle: begin
        if (bus_io.swap_req) begin
          state_d = StXfer;
          idx_d   = '0;
        end
      end
      StXfer: begin
        bus_io.swap_busy  = 1'b1;
        bus_io.pipe_stall = 1'b1;
`ifdef FPR_SWAP_64_EN
        bus_io.reg_mode    = ModePair;
        bus_io.reg_id_rs   = ureg_fr({idx_q[2:0], 1'b0});
        bus_io.reg_id_rt   = ureg_fr({idx_q[2:0], 1'b1});
        bus_io.reg_st_mode = ModePair;
        bus_io.reg_id_ro   = ureg_fr({idx_q[2:0], 1'b1});
`else
        bus_io.reg_mode    = ModeSingle;
        bus_io.reg_id_rs   = ureg_fr(idx_q);
        bus_io.reg_id_rt   = ureg_xf(idx_q);
        bus_io.reg_st_mode = ModeSingle;
        bus_io.reg_id_ro   = ureg_xf(idx_q);
`endif
        state_d = StWrbk;
      end
      StWrbk: begin
        bus_io.swap_busy  = 1'b1;
        bus_io.pipe_stall = 1'b1;
        bus_io.swap_done  = idx_last;
        bus_io.reg_mode   = ModeSingle;
        bus_io.reg_id_rs  = UREG_ZZR;
        bus_io.reg_id_rt  = UREG_ZZR;
`ifdef FPR_SWAP_64_EN
        bus_io.reg_st_mode = ModePair;
        bus_io.reg_id_ro   = ureg_fr({idx_q[2:0], 1'b0});
`else
        bus_io.reg_st_mode = ModeSingle;
        bus_io.reg_id_ro   = ureg_fr(idx_q);
`endif
        if (idx_last) begin
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = StXfer;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write data and XF hold capture.
  always_comb begin
    bus_io.reg_val_ro = bus_io.pipe_val_ro;
    hold_d            = hold_q;
    unique case (state_q)
      StXfer: begin
        bus_io.reg_val_ro = bus_io.reg_val_rs;
`ifdef FPR_SWAP_64_EN
        hold_d = bus_io.reg_val_rt;
`else
        hold_d = bus_io.reg_val_rt[31:0];
`endif
      end
      StWrbk: begin
`ifdef FPR_SWAP_64_EN
        bus_io.reg_val_ro = hold_q;
`else
        bus_io.reg_val_ro = {32'h0, hold_q};
`endif
      end
      default: ;
    endcase
  end

`ifndef FPR_SWAP_64_EN
  logic unused_rt_hi;
  assign unused_rt_hi = ^bus_io.reg_val_rt[63:32];
`endif

endmodule

// File: tb/tb_fpr_bank_swap_seq.sv
// Bench for fpr_bank_swap_seq: register-file model, scoreboard of expected write-port traffic.
module tb_fpr_bank_swap_seq;
  import fpr_bank_swap_seq_pkg::*;

`ifdef FPR_SWAP_64_EN
  localparam int ExpBusy     = 16;
  localparam int SwappedRst  = 6;
`else
  localparam int ExpBusy     = 32;
  localparam int SwappedRst  = 3;
`endif

  typedef struct {
    logic [6:0]  id;
    logic [63:0] val;
    logic [1:0]  st;
    logic        done;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  fpr_bank_swap_seq_if bus ();

  fpr_bank_swap_seq dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_at = 0;
  int busy_run = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [31:0] fr[16];
  logic [31:0] xf[16];
  logic [31:0] fpul;
  logic [31:0] exp_fr[16];
  logic [31:0] exp_xf[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Register file model: pair mode with an odd FR id addresses the XF pair.
  function automatic logic [63:0] rf_rd(input logic [6:0] id, input logic [1:0] mode);
    logic [3:0] n;
    n = id[3:0];
    rf_rd = '0;
    if ((id & 7'h70) == UREG_FR0) begin
      if (mode == ModePair)
        rf_rd = n[0] ? {xf[{n[3:1], 1'b0}], xf[{n[3:1], 1'b1}]}
                     : {fr[{n[3:1], 1'b0}], fr[{n[3:1], 1'b1}]};
      else
        rf_rd = {32'h0, fr[n]};
    end else if ((id & 7'h70) == UREG_XF0) begin
      rf_rd = {32'h0, xf[n]};
    end else if (id == UREG_FPUL) begin
      rf_rd = {32'h0, fpul};
    end
  endfunction

  always_comb begin
    bus.reg_val_rs = rf_rd(bus.reg_id_rs, bus.reg_mode);
    bus.reg_val_rt = rf_rd(bus.reg_id_rt, bus.reg_mode);
  end

  logic [3:0] wn;
  assign wn = bus.reg_id_ro[3:0];

  always @(posedge clk_i) begin
    if ((bus.reg_id_ro & 7'h70) == UREG_FR0) begin
      if (bus.reg_st_mode == ModePair) begin
        if (wn[0]) begin
          xf[{wn[3:1], 1'b0}] <= bus.reg_val_ro[63:32];
          xf[{wn[3:1], 1'b1}] <= bus.reg_val_ro[31:0];
        end else begin
          fr[{wn[3:1], 1'b0}] <= bus.reg_val_ro[63:32];
          fr[{wn[3:1], 1'b1}] <= bus.reg_val_ro[31:0];
        end
      end else begin
        fr[wn] <= bus.reg_val_ro[31:0];
      end
    end else if ((bus.reg_id_ro & 7'h70) == UREG_XF0) begin
      xf[wn] <= bus.reg_val_ro[31:0];
    end else if (bus.reg_id_ro == UREG_FPUL) begin
      fpul <= bus.reg_val_ro[31:0];
    end
  end

  // Monitor: every busy cycle must match the next expected write-port transaction.
  always @(negedge clk_i) begin
    if (bus.swap_busy) begin
      busy_run++;
      chk("stall_while_busy", {63'h0, bus.pipe_stall}, 64'h1);
      chk("ro_not_fpul", {63'h0, bus.reg_id_ro == UREG_FPUL}, 64'h0);
      if (sb_q.size() == 0) begin
        chk("unexpected_busy", {63'h0, bus.swap_busy}, 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wr_id", {57'h0, bus.reg_id_ro}, {57'h0, mon_e.id});
        chk("wr_val", bus.reg_val_ro, mon_e.val);
        chk("wr_st_mode", {62'h0, bus.reg_st_mode}, {62'h0, mon_e.st});
        chk("done_pulse", {63'h0, bus.swap_done}, {63'h0, mon_e.done});
      end
    end else begin
      busy_run = 0;
      if (bus.swap_done) chk("done_while_idle", 64'h1, 64'h0);
    end
    if (bus.swap_done) begin
      done_cnt++;
      done_at = busy_run;
    end
  end

  task automatic push_swap();
    exp_t e;
`ifdef FPR_SWAP_64_EN
    for (int k = 0; k < 8; k++) begin
      e.id = ureg_fr(4'(2 * k + 1));
      e.val = {exp_fr[2*k], exp_fr[2*k+1]};
      e.st = ModePair;
      e.done = 1'b0;
      sb_q.push_back(e);
      e.id = ureg_fr(4'(2 * k));
      e.val = {exp_xf[2*k], exp_xf[2*k+1]};
      e.done = (k == 7);
      sb_q.push_back(e);
    end
`else
    for (int i = 0; i < 16; i++) begin
      e.id = ureg_xf(4'(i));
      e.val = {32'h0, exp_fr[i]};
      e.st = ModeSingle;
      e.done = 1'b0;
      sb_q.push_back(e);
      e.id = ureg_fr(4'(i));
      e.val = {32'h0, exp_xf[i]};
      e.done = (i == 15);
      sb_q.push_back(e);
    end
`endif
  endtask

  task automatic apply_swap(input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      t = exp_fr[i];
      exp_fr[i] = exp_xf[i];
      exp_xf[i] = t;
    end
  endtask

  task automatic idle_pipe();
    bus.swap_req     = 1'b0;
    bus.pipe_id_rs   = UREG_ZZR;
    bus.pipe_id_rt   = UREG_ZZR;
    bus.pipe_mode    = ModeSingle;
    bus.pipe_id_ro   = UREG_ZZR;
    bus.pipe_val_ro  = '0;
    bus.pipe_st_mode = ModeSingle;
  endtask

  task automatic pipe_write(input logic [6:0] id, input logic [31:0] val);
    @(negedge clk_i);
    bus.pipe_id_ro  = id;
    bus.pipe_val_ro = {32'h0, val};
    @(negedge clk_i);
    idle_pipe();
  endtask

  // Leaves the caller at the negedge of busy cycle 1.
  task automatic swap_pulse();
    @(negedge clk_i);
    bus.swap_req = 1'b1;
    push_swap();
    @(negedge clk_i);
    idle_pipe();
  endtask

  task automatic finish_swap(input string tag, input int done0);
    repeat (ExpBusy + 2) @(negedge clk_i);
    chk({tag, "_idle_after"}, {63'h0, bus.swap_busy}, 64'h0);
    chk({tag, "_done_once"}, 64'(done_cnt - done0), 64'h1);
    chk({tag, "_done_cycle"}, 64'(done_at), 64'(ExpBusy));
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'h0);
  endtask

  task automatic check_contents(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_fr"}, {32'h0, fr[i]}, {32'h0, exp_fr[i]});
      chk({tag, "_xf"}, {32'h0, xf[i]}, {32'h0, exp_xf[i]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_ni = 1'b0;
    idle_pipe();
    repeat (2) @(negedge clk_i);
    chk("rst_busy", {63'h0, bus.swap_busy}, 64'h0);
    chk("rst_done", {63'h0, bus.swap_done}, 64'h0);
    chk("rst_stall", {63'h0, bus.pipe_stall}, 64'h0);
    rst_ni = 1'b1;

    // Idle pass-through of every register-file-side output (7'h7F is unmapped).
    @(negedge clk_i);
    bus.pipe_id_rs   = 7'h25;
    bus.pipe_id_rt   = 7'h33;
    bus.pipe_mode    = 2'd2;
    bus.pipe_id_ro   = 7'h7F;
    bus.pipe_val_ro  = 64'h0123_4567_89AB_CDEF;
    bus.pipe_st_mode = 2'd3;
    #1;
    chk("pt_id_rs", {57'h0, bus.reg_id_rs}, 64'h25);
    chk("pt_id_rt", {57'h0, bus.reg_id_rt}, 64'h33);
    chk("pt_mode", {62'h0, bus.reg_mode}, 64'h2);
    chk("pt_id_ro", {57'h0, bus.reg_id_ro}, 64'h7F);
    chk("pt_val_ro", bus.reg_val_ro, 64'h0123_4567_89AB_CDEF);
    chk("pt_st_mode", {62'h0, bus.reg_st_mode}, 64'h3);
    idle_pipe();

    for (int i = 0; i < 16; i++) begin
      pipe_write(ureg_fr(4'(i)), 32'h1000 + i);
      pipe_write(ureg_xf(4'(i)), 32'h2000 + i);
      exp_fr[i] = 32'h1000 + i;
      exp_xf[i] = 32'h2000 + i;
    end
    pipe_write(UREG_FPUL, 32'hCAFE_F00D);

    // Basic swap.
    d0 = done_cnt;
    swap_pulse();
    finish_swap("basic", d0);
    for (int i = 0; i < 16; i++) begin
      chk("basic_fr", {32'h0, fr[i]}, {32'h0, 32'h2000 + i});
      chk("basic_xf", {32'h0, xf[i]}, {32'h0, 32'h1000 + i});
    end
    chk("fpul_kept", {32'h0, fpul}, 64'hCAFE_F00D);
    apply_swap(16);

    // Pipeline write in the request cycle lands before the sweep reads FR3.
    d0 = done_cnt;
    @(negedge clk_i);
    bus.swap_req    = 1'b1;
    bus.pipe_id_ro  = ureg_fr(4'd3);
    bus.pipe_val_ro = 64'hDEAD_BEEF;
    exp_fr[3] = 32'hDEAD_BEEF;
    push_swap();
    @(negedge clk_i);
    idle_pipe();
    finish_swap("pass", d0);
    chk("pass_xf3", {32'h0, xf[3]}, 64'hDEAD_BEEF);
    chk("pass_fr3", {32'h0, fr[3]}, 64'h1003);
    apply_swap(16);
    check_contents("pass");

    // Pipeline write and second request at cycle 10 are dropped.
    d0 = done_cnt;
    swap_pulse();
    repeat (9) @(negedge clk_i);
    bus.swap_req    = 1'b1;
    bus.pipe_id_ro  = ureg_fr(4'd5);
    bus.pipe_val_ro = 64'h5555_5555;
    #1;
    chk("ign_stall", {63'h0, bus.pipe_stall}, 64'h1);
    chk("ign_ro_blocked", {63'h0, bus.reg_id_ro == ureg_fr(4'd5)}, 64'h0);
    @(negedge clk_i);
    idle_pipe();
    finish_swap("ign", d0);
    apply_swap(16);
    check_contents("ign");

    // Reset in cycle 7 aborts the sweep.
    d0 = done_cnt;
    swap_pulse();
    repeat (6) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_busy", {63'h0, bus.swap_busy}, 64'h0);
    chk("rst_mid_stall", {63'h0, bus.pipe_stall}, 64'h0);
    chk("rst_mid_done", {63'h0, bus.swap_done}, 64'h0);
    chk("rst_mid_id_ro", {57'h0, bus.reg_id_ro}, {57'h0, UREG_ZZR});
    sb_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'h0);
    apply_swap(SwappedRst);
    check_contents("rst_mid");
    chk("fpul_final", {32'h0, fpul}, 64'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
